fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its prefetch buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned DEFAULT_DEPTH        = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO with synchronous flush; head reads as zero when empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers responses with their PCs,
// and discards responses that belong to the path abandoned by a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         instr_valid_o,
    output logic [31:0]  instr_o,
    output logic [31:0]  instr_pc_o,
    input  logic         instr_ready_i,
    output fetch_state_t state_o
);

    // Handshakes: a fetch is accepted on a cycle with imem_req_o && imem_gnt_i, and its
    // response returns later, in order, on imem_rvalid_i; an instruction is consumed on a
    // cycle with instr_valid_o && instr_ready_i. Neither side waits on the other's ack.

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;
    logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;
    logic [31:0]      pcq_mem_q [DEPTH];

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [63:0]      fifo_rdata;
    logic [CNT_W:0]   inflight;
    logic [CNT_W-1:0] pending_drop;
    logic             grant;
    logic             rsp_accept;
    logic             fifo_pop;

    assign imem_addr_o  = align_pc(fetch_pc_q);
    assign inflight     = {1'b0, fifo_count} + {1'b0, outst_q};
    assign imem_req_o   = (state_q == FETCH) && !redirect_i && (inflight < (CNT_W+1)'(DEPTH));
    assign grant        = imem_req_o && imem_gnt_i;
    // With nothing outstanding, a response can only be a leftover from before a reset.
    assign rsp_accept   = imem_rvalid_i && (state_q == FETCH) && !redirect_i && (outst_q != '0);
    assign fifo_pop     = instr_valid_o && instr_ready_i;
    assign pending_drop = drop_q + outst_q;
    assign state_o      = state_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        if (redirect_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
            outst_d    = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            drop_d     = (imem_rvalid_i && (pending_drop != '0)) ? pending_drop - CNT_W'(1)
                                                                  : pending_drop;
            state_d    = (drop_d != '0) ? DRAIN : FETCH;
        end else begin
            unique case (state_q)
                RESET: state_d = FETCH;
                FETCH: begin
                    if (grant) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        pcq_wr_d   = pcq_wr_q + PTR_W'(1);
                    end
                    if (rsp_accept) begin
                        pcq_rd_d = pcq_rd_q + PTR_W'(1);
                    end
                    unique case ({grant, rsp_accept})
                        2'b10:   outst_d = outst_q + CNT_W'(1);
                        2'b01:   outst_d = outst_q - CNT_W'(1);
                        default: outst_d = outst_q;
                    endcase
                end
                DRAIN: begin
                    if (imem_rvalid_i && (drop_q != '0)) begin
                        drop_d = drop_q - CNT_W'(1);
                    end
                    if (drop_d == '0) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = RESET;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RESET;
            fetch_pc_q <= RESET_VECTOR;
            outst_q    <= '0;
            drop_q     <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
        end
    end

    // Issue address of every granted request, consumed in order as responses return.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            pcq_mem_q[pcq_wr_q] <= imem_addr_o;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (rsp_accept),
        .data_i  ({imem_rdata_i, pcq_mem_q[pcq_rd_q]}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_rdata[63:32];
    assign instr_pc_o    = fifo_rdata[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an instruction-memory responder and an expected queue.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_gnt_i;
    logic         imem_rvalid_i;
    logic [31:0]  imem_rdata_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         instr_valid_o;
    logic [31:0]  instr_o;
    logic [31:0]  instr_pc_o;
    logic         instr_ready_i;
    fetch_state_t state_o;

    int vectors = 0;
    int errors  = 0;
    int grants  = 0;
    int pops    = 0;
    int g0, p0;

    logic [63:0] exp_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] exp_addr;
    bit          gnt_en, rsp_en, ready_en, redir_req;
    logic [31:0] redir_pc;

    fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then observe what the rising edge will do.
    task automatic cycle();
        @(negedge clk_i);
        if (rsp_en && rsp_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(rsp_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        imem_gnt_i    = gnt_en;
        instr_ready_i = ready_en;
        redirect_i    = redir_req;
        redirect_pc_i = redir_pc;
        redir_req     = 1'b0;
        #1;
        if (imem_req_o && imem_gnt_i) begin
            check("grant_addr", imem_addr_o, exp_addr);
            rsp_q.push_back(imem_addr_o);
            exp_q.push_back({exp_addr, mem_word(exp_addr)});
            exp_addr = exp_addr + 32'd4;
            grants++;
        end
        if (redirect_i) begin
            exp_q.delete();
            exp_addr = {redirect_pc_i[31:2], 2'b00};
        end else if (instr_valid_o && instr_ready_i) begin
            pops++;
            check("instr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check("instr_pc_data", {instr_pc_o, instr_o}, exp_q.pop_front());
            end
        end
    endtask

    task automatic settle();
        gnt_en   = 1'b0;
        ready_en = 1'b1;
        rsp_en   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (rsp_q.size() == 0 && exp_q.size() == 0) break;
        end
        check("settle_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        gnt_en = 0; rsp_en = 0; ready_en = 0; redir_req = 0; redir_pc = '0;
        exp_addr = RV;

        // Reset values
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_req", imem_req_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_pc", instr_pc_o, 0);
        check("rst_addr", imem_addr_o, RV);
        check("rst_state", state_o, RESET);

        // Streaming after release: first instruction three edges later
        @(negedge clk_i);
        rst_ni = 1'b1;
        gnt_en = 1; rsp_en = 1; ready_en = 1;
        cycle();
        check("rel_state", state_o, FETCH);
        check("rel_req", imem_req_o, 1);
        check("rel_valid1", instr_valid_o, 0);
        cycle();
        check("rel_valid2", instr_valid_o, 0);
        cycle();
        check("rel_valid3", instr_valid_o, 1);
        check("first_pc", instr_pc_o, RV);
        repeat (12) cycle();
        settle();

        // Back-pressure: the buffer limits issue to DEPTH requests
        ready_en = 0; gnt_en = 1; rsp_en = 1;
        g0 = grants;
        repeat (8) cycle();
        check("bp_grants", 64'(grants - g0), 64'(DEPTH));
        check("bp_req_low", imem_req_o, 0);
        check("bp_valid", instr_valid_o, 1);
        ready_en = 1;
        g0 = grants; p0 = pops;
        cycle();
        ready_en = 0;
        repeat (4) cycle();
        check("bp_one_grant", 64'(grants - g0), 64'd1);
        check("bp_one_pop", 64'(pops - p0), 64'd1);
        settle();

        // Redirect with two requests outstanding
        rsp_en = 0; gnt_en = 1;
        repeat (2) cycle();
        gnt_en = 0;
        cycle();
        redir_req = 1; redir_pc = 32'h0000_0100;
        cycle();
        check("rd_req_in_redirect", imem_req_o, 0);
        rsp_en = 1; gnt_en = 1;
        cycle();
        check("rd_state_drain", state_o, DRAIN);
        check("rd_valid_after", instr_valid_o, 0);
        check("rd_req_drain", imem_req_o, 0);
        cycle();
        check("rd_state_drain2", state_o, DRAIN);
        cycle();
        check("rd_state_fetch", state_o, FETCH);
        check("rd_addr", imem_addr_o, 32'h0000_0100);
        repeat (8) cycle();
        settle();

        // Grant stall keeps the request stable; redirect during the wait retargets it
        gnt_en = 0;
        repeat (5) begin
            cycle();
            check("stall_req", imem_req_o, 1);
            check("stall_addr", imem_addr_o, exp_addr);
        end
        redir_req = 1; redir_pc = 32'h0000_0202;
        cycle();
        check("stall_rd_req", imem_req_o, 0);
        cycle();
        check("stall_rd_state", state_o, FETCH);
        check("stall_rd_addr", imem_addr_o, 32'h0000_0200);
        gnt_en = 1;
        repeat (6) cycle();
        settle();

        // Redirect in the same cycle as the only outstanding response
        rsp_en = 0; gnt_en = 1;
        cycle();
        gnt_en = 0;
        cycle();
        rsp_en = 1; redir_req = 1; redir_pc = 32'h0000_0300;
        cycle();
        check("same_rvalid_driven", imem_rvalid_i, 1);
        cycle();
        check("same_state", state_o, FETCH);
        check("same_valid", instr_valid_o, 0);
        check("same_req", imem_req_o, 1);
        check("same_addr", imem_addr_o, 32'h0000_0300);
        gnt_en = 1;
        repeat (6) cycle();
        settle();

        // Asynchronous reset with three requests outstanding and one buffered
        ready_en = 0; rsp_en = 0; gnt_en = 1;
        repeat (4) cycle();
        gnt_en = 0; rsp_en = 1;
        cycle();
        rsp_en = 0;
        cycle();
        check("pre_reset_valid", instr_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_req", imem_req_o, 0);
        check("async_valid", instr_valid_o, 0);
        check("async_instr", instr_o, 0);
        check("async_pc", instr_pc_o, 0);
        check("async_state", state_o, RESET);
        check("async_addr", imem_addr_o, RV);
        exp_q.delete();
        exp_addr = RV;
        @(negedge clk_i);
        rst_ni = 1'b1;
        ready_en = 1; rsp_en = 1; gnt_en = 0;
        repeat (5) begin
            cycle();
            check("late_rsp_valid", instr_valid_o, 0);
        end
        check("late_rsp_all_sent", 64'(rsp_q.size()), 64'd0);
        gnt_en = 1;
        repeat (10) cycle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
